// File: rtl/memory_matrix_pkg.sv
// memory_matrix_pkg: shared tile count, game FSM state encoding and one-hot helpers
package memory_matrix_pkg;
   localparam int N_TILES = 8;
   typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, RELEASE = 2'd2} state_t;
   function automatic int popcount(input logic [N_TILES-1:0] v);
      int n = 0;
      for (int i = 0; i < N_TILES; i++) if (v[i]) n++;
      return n;
   endfunction
   function automatic logic is_onehot(input logic [N_TILES-1:0] v);
      return popcount(v) == 1;
   endfunction
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: one raw active-low button -> synchronised, debounced level and a 1-cycle press pulse
//   clk    system clock
//   reset  synchronous, active-low
//   btn_n  raw button, active-low, asynchronous to clk
//   busy   button not fully at rest (synced press seen or debounced level high)
//   rise   1-cycle pulse on a debounced rising edge (press event)
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_W = 19
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_n,
   output logic busy,
   output logic rise
);
   logic [1:0] sync;
   logic [CNT_W-1:0] cnt;
   logic level, synced;
   assign synced = ~sync[1];
   assign busy = synced | level;
   // Synchroniser resets to "pressed" so a button held through reset keeps
   // busy asserted until it debounces, letting RELEASE swallow its press event.
   always_ff @(posedge clk) begin
      if (!reset) begin
         sync  <= 2'b00;
         cnt   <= '0;
         level <= 1'b0;
         rise  <= 1'b0;
      end else begin
         sync <= {sync[0], btn_n};
         rise <= 1'b0;
         if (synced == level) cnt <= '0;
         else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            cnt   <= '0;
            level <= synced;
            rise  <= synced;
         end else cnt <= cnt + 1'b1;
      end
   end
endmodule

// File: rtl/guess_capture.sv
// guess_capture: debounced tile buttons -> one-hot guess under valid/ready, with duplicate/multi-press rejection
//   clk             system clock
//   reset           synchronous, active-low
//   btn_n           raw tile buttons, active-low
//   enable          guesses accepted only while high
//   clear           new round: clears history, withdraws guess
//   guess_ready     consumer accepts guess this cycle
//   guess_valid     guess holds a valid one-hot tile
//   guess           one-hot tile, 0 while guess_valid=0
//   guess_accepted  1-cycle pulse after valid&ready
//   dup_err         1-cycle pulse: press of a tile already in history
//   multi_err       1-cycle pulse: more than one press event in a cycle
//   history         tiles accepted since last clear/reset
module guess_capture
   import memory_matrix_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_W = 19
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [N_TILES-1:0] btn_n,
   input  logic               enable,
   input  logic               clear,
   input  logic               guess_ready,
   output logic               guess_valid,
   output logic [N_TILES-1:0] guess,
   output logic               guess_accepted,
   output logic               dup_err,
   output logic               multi_err,
   output logic [N_TILES-1:0] history
);
   logic [N_TILES-1:0] busy, ev, guess_nx, history_nx;
   logic acc_nx, dup_nx, multi_nx;
   state_t state, state_nx;
   for (genvar i = 0; i < N_TILES; i++) begin : g_db
      btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db (
         .clk(clk), .reset(reset), .btn_n(btn_n[i]), .busy(busy[i]), .rise(ev[i])
      );
   end
   assign guess_valid = state == HOLD;
   always_ff @(posedge clk) begin
      if (!reset) begin
         state          <= RELEASE;
         guess          <= '0;
         history        <= '0;
         guess_accepted <= 1'b0;
         dup_err        <= 1'b0;
         multi_err      <= 1'b0;
      end else begin
         state          <= state_nx;
         guess          <= guess_nx;
         history        <= history_nx;
         guess_accepted <= acc_nx;
         dup_err        <= dup_nx;
         multi_err      <= multi_nx;
      end
   end
   // A handshake offered in the same cycle enable drops still completes,
   // since guess_valid was high in that cycle.
   always_comb begin
      state_nx   = state;
      guess_nx   = guess;
      history_nx = history;
      acc_nx     = 1'b0;
      dup_nx     = 1'b0;
      multi_nx   = 1'b0;
      if (clear) begin
         state_nx   = RELEASE;
         guess_nx   = '0;
         history_nx = '0;
      end else begin
         case (state)
            IDLE: if (enable && |ev) begin
               if (!is_onehot(ev)) begin
                  multi_nx = 1'b1;
                  state_nx = RELEASE;
               end else if (|(ev & history)) begin
                  dup_nx   = 1'b1;
                  state_nx = RELEASE;
               end else begin
                  guess_nx = ev;
                  state_nx = HOLD;
               end
            end
            HOLD: if (guess_ready) begin
               history_nx = history | guess;
               acc_nx     = 1'b1;
               guess_nx   = '0;
               state_nx   = RELEASE;
            end else if (!enable) begin
               guess_nx = '0;
               state_nx = RELEASE;
            end
            RELEASE: state_nx = |busy ? RELEASE : IDLE;
            default: state_nx = RELEASE;
         endcase
      end
   end
endmodule
